// File: rtl/reg_bank.sv
// Multi-register bank: accumulator write-back, one-cycle-staged memory loads,
// two combinational read ports and a full-bank shadow for save/restore/swap.
module reg_bank #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter bit BYPASS = 1'b1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             acc_op,
  input  logic [AW-1:0]    acc_addr,
  input  logic [WIDTH-1:0] acc_val,
  input  logic             load,
  input  logic [AW-1:0]    load_addr,
  input  logic [WIDTH-1:0] data_val,
  input  logic             shadow_save,
  input  logic             shadow_restore,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             load_pending,
  output logic             load_drop
);

  logic [WIDTH-1:0] regs   [DEPTH];
  logic [WIDTH-1:0] shadow [DEPTH];
  logic             pend_v;
  logic [AW-1:0]    pend_addr;
  logic [WIDTH-1:0] pend_data;

  logic acc_hits_pend;
  assign acc_hits_pend = acc_op && (acc_addr == pend_addr);

  // Per-register priority on each edge: restore, then accumulator, then load commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i]   <= '0;
        shadow[i] <= '0;
      end
      pend_v    <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
      load_drop <= 1'b0;
    end else begin
      pend_v <= load;
      if (load) begin
        pend_addr <= load_addr;
        pend_data <= data_val;
      end

      load_drop <= pend_v && (shadow_restore || acc_hits_pend);

      for (int i = 0; i < DEPTH; i++) begin
        if (shadow_restore)
          regs[i] <= shadow[i];
        else if (acc_op && (acc_addr == AW'(i)))
          regs[i] <= acc_val;
        else if (pend_v && (pend_addr == AW'(i)))
          regs[i] <= pend_data;

        if (shadow_save)
          shadow[i] <= regs[i];
      end
    end
  end

  assign load_pending = pend_v;

  // Forwarding only covers the staged load; same-cycle accumulator writes show up next cycle.
  always_comb begin
    rd_data_a = regs[rd_addr_a];
    rd_data_b = regs[rd_addr_b];
    if (BYPASS && pend_v && (rd_addr_a == pend_addr))
      rd_data_a = pend_data;
    if (BYPASS && pend_v && (rd_addr_b == pend_addr))
      rd_data_b = pend_data;
    if (reset) begin
      rd_data_a = '0;
      rd_data_b = '0;
    end
  end

endmodule

// File: tb/tb_reg_bank.sv
// Randomised and directed bench for reg_bank; two instances (with and without
// load forwarding) share the same stimulus and are checked against one model.
module tb_reg_bank;

  typedef logic [15:0] bank_t [8];

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        acc_op = 1'b0;
  logic [2:0]  acc_addr = '0;
  logic [15:0] acc_val = '0;
  logic        load = 1'b0;
  logic [2:0]  load_addr = '0;
  logic [15:0] data_val = '0;
  logic        shadow_save = 1'b0;
  logic        shadow_restore = 1'b0;
  logic [2:0]  rd_addr_a = '0;
  logic [2:0]  rd_addr_b = '0;

  logic [15:0] rd_a1, rd_b1, rd_a0, rd_b0;
  logic        pend1, drop1, pend0, drop0;

  int tests = 0;
  int failed = 0;

  bank_t       m_regs, m_shadow;
  bit          m_pv, m_drop;
  logic [2:0]  m_pa;
  logic [15:0] m_pd;

  always #5 clk = ~clk;

  reg_bank #(.WIDTH(16), .DEPTH(8), .BYPASS(1'b1)) dut (
    .clk(clk), .reset(reset), .acc_op(acc_op), .acc_addr(acc_addr), .acc_val(acc_val),
    .load(load), .load_addr(load_addr), .data_val(data_val),
    .shadow_save(shadow_save), .shadow_restore(shadow_restore),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_a1), .rd_data_b(rd_b1), .load_pending(pend1), .load_drop(drop1)
  );

  reg_bank #(.WIDTH(16), .DEPTH(8), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .acc_op(acc_op), .acc_addr(acc_addr), .acc_val(acc_val),
    .load(load), .load_addr(load_addr), .data_val(data_val),
    .shadow_save(shadow_save), .shadow_restore(shadow_restore),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_a0), .rd_data_b(rd_b0), .load_pending(pend0), .load_drop(drop0)
  );

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_rd(input logic [2:0] addr, input bit byp);
    if (reset) return 16'h0;
    if (byp && m_pv && m_pa == addr) return m_pd;
    return m_regs[addr];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_regs[i] = '0;
      m_shadow[i] = '0;
    end
    m_pv = 0; m_pa = '0; m_pd = '0; m_drop = 0;
  endtask

  task automatic check_ports(input string tag);
    checkOutput({tag, ".a_byp"}, rd_a1, exp_rd(rd_addr_a, 1'b1));
    checkOutput({tag, ".b_byp"}, rd_b1, exp_rd(rd_addr_b, 1'b1));
    checkOutput({tag, ".a_nobyp"}, rd_a0, exp_rd(rd_addr_a, 1'b0));
    checkOutput({tag, ".b_nobyp"}, rd_b0, exp_rd(rd_addr_b, 1'b0));
    checkOutput({tag, ".pend"}, {15'b0, pend1}, {15'b0, m_pv});
    checkOutput({tag, ".pend_nb"}, {15'b0, pend0}, {15'b0, m_pv});
    checkOutput({tag, ".drop"}, {15'b0, drop1}, {15'b0, m_drop});
    checkOutput({tag, ".drop_nb"}, {15'b0, drop0}, {15'b0, m_drop});
  endtask

  // One clock edge: the model applies writes in ascending priority so the last one wins.
  task automatic applyStimulus(input string tag);
    bank_t       n_regs, n_shadow;
    bit          n_pv, n_drop;
    logic [2:0]  n_pa;
    logic [15:0] n_pd;
    n_regs = m_regs;
    if (m_pv) n_regs[m_pa] = m_pd;
    if (acc_op) n_regs[acc_addr] = acc_val;
    if (shadow_restore) n_regs = m_shadow;
    n_shadow = shadow_save ? m_regs : m_shadow;
    n_drop = m_pv && (shadow_restore || (acc_op && acc_addr == m_pa));
    n_pv = load;
    n_pa = load ? load_addr : m_pa;
    n_pd = load ? data_val : m_pd;
    @(posedge clk);
    m_regs = n_regs; m_shadow = n_shadow; m_drop = n_drop;
    m_pv = n_pv; m_pa = n_pa; m_pd = n_pd;
    #1;
    check_ports(tag);
  endtask

  task automatic idle();
    acc_op = 0; load = 0; shadow_save = 0; shadow_restore = 0;
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = 3'(i);
      rd_addr_b = 3'(7 - i);
      #1;
      check_ports(tag);
    end
  endtask

  initial begin
    model_reset();
    #2 reset = 1'b1;
    rd_addr_a = 3'd3;
    #1;
    checkOutput("rst_rd_a", rd_a1, 16'h0);
    checkOutput("rst_pend", {15'b0, pend1}, 16'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus("idle");
    checkOutput("idle_rd_a3", rd_a1, 16'h0);
    checkOutput("idle_drop", {15'b0, drop1}, 16'h0);

    acc_op = 1; acc_addr = 3'd2; acc_val = 16'h1234; rd_addr_a = 3'd2;
    applyStimulus("acc2");
    checkOutput("acc2_val", rd_a1, 16'h1234);
    idle();
    load = 1; load_addr = 3'd5; data_val = 16'hBEEF; rd_addr_b = 3'd5;
    applyStimulus("ld5_req");
    checkOutput("ld5_byp_1cyc", rd_b1, 16'hBEEF);
    checkOutput("ld5_nobyp_1cyc", rd_b0, 16'h0000);
    idle();
    applyStimulus("ld5_commit");
    checkOutput("ld5_nobyp_2cyc", rd_b0, 16'hBEEF);

    load = 1; load_addr = 3'd4; data_val = 16'hAAAA; rd_addr_a = 3'd4; rd_addr_b = 3'd6;
    applyStimulus("conf_ld");
    idle();
    acc_op = 1; acc_addr = 3'd4; acc_val = 16'h5555;
    applyStimulus("conf_acc");
    checkOutput("conf_drop", {15'b0, drop1}, 16'h1);
    checkOutput("conf_reg4", rd_a0, 16'h5555);
    idle();
    applyStimulus("conf_after");
    checkOutput("conf_drop_once", {15'b0, drop1}, 16'h0);

    load = 1; load_addr = 3'd4; data_val = 16'hAAAA;
    applyStimulus("nconf_ld");
    idle();
    acc_op = 1; acc_addr = 3'd6; acc_val = 16'h5555;
    applyStimulus("nconf_acc");
    checkOutput("nconf_reg4", rd_a0, 16'hAAAA);
    checkOutput("nconf_reg6", rd_b0, 16'h5555);
    checkOutput("nconf_nodrop", {15'b0, drop1}, 16'h0);
    idle();

    for (int i = 0; i < 8; i++) begin
      acc_op = 1; acc_addr = 3'(i); acc_val = 16'(i * 16'h0101);
      applyStimulus("fill");
    end
    idle(); shadow_save = 1;
    applyStimulus("save");
    for (int i = 0; i < 8; i++) begin
      idle(); acc_op = 1; acc_addr = 3'(i); acc_val = 16'hFFFF;
      applyStimulus("clobber");
    end
    idle(); shadow_restore = 1;
    applyStimulus("restore");
    idle();
    sweep("restored");
    rd_addr_a = 3'd5;
    #1 checkOutput("restored_r5", rd_a1, 16'h0505);

    for (int i = 0; i < 8; i++) begin
      acc_op = 1; acc_addr = 3'(i); acc_val = 16'hFFFF;
      applyStimulus("preswap");
    end
    idle(); shadow_save = 1; shadow_restore = 1;
    applyStimulus("swap");
    idle();
    rd_addr_a = 3'd3;
    #1 checkOutput("swap_regs3", rd_a1, 16'h0303);
    sweep("swapped_regs");
    shadow_restore = 1;
    applyStimulus("swap_back");
    idle();
    rd_addr_a = 3'd3;
    #1 checkOutput("swap_shadow3", rd_a1, 16'hFFFF);

    for (int i = 0; i < 4; i++) begin
      load = 1; load_addr = 3'(i); data_val = 16'(16'h10 + i);
      applyStimulus("burst");
      checkOutput("burst_pend", {15'b0, pend1}, 16'h1);
    end
    idle();
    #1 reset = 1'b1;
    model_reset();
    #1 check_ports("rst_mid");
    @(negedge clk) reset = 1'b0;
    applyStimulus("post_rst");
    rd_addr_a = 3'd3; rd_addr_b = 3'd0;
    #1 checkOutput("post_rst_r3", rd_a0, 16'h0);
    checkOutput("post_rst_pend", {15'b0, pend1}, 16'h0);
    sweep("post_rst_sweep");

    for (int n = 0; n < 400; n++) begin
      acc_op = 1'($urandom_range(0, 1));
      acc_addr = 3'($urandom_range(0, 3));
      acc_val = 16'($urandom);
      load = 1'($urandom_range(0, 1));
      load_addr = 3'($urandom_range(0, 3));
      data_val = 16'($urandom);
      shadow_save = ($urandom_range(0, 9) == 0);
      shadow_restore = ($urandom_range(0, 9) == 0);
      rd_addr_a = 3'($urandom);
      rd_addr_b = 3'($urandom_range(0, 3));
      applyStimulus("rand");
    end
    idle();
    applyStimulus("final");
    sweep("final_sweep");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
